// File: rtl/keypad_encoder_pkg.sv
// keypad_encoder_pkg: shared key codes, FSM states and scan classifier
package keypad_encoder_pkg;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_OPT_BASE = 4'd10;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
  typedef struct packed {
    res_t res;
    logic [3:0] code;
  } scan_t;
  function automatic scan_t classify(input logic [15:0] keys);
    scan_t s;
    s.res = RES_NONE;
    s.code = '0;
    for (int i = 0; i < 16; i++)
      if (keys[i]) begin
        s.res = (s.res == RES_NONE) ? RES_SINGLE : RES_MULTI;
        s.code = 4'(i);
      end
    return s;
  endfunction
endpackage

// File: rtl/keypad_encoder_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count filter advanced on en
module key_debounce #(
  parameter int COUNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(COUNT + 1);
  logic s1_q, s2_q, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (en) begin
      cnt_d = (s2_q != out_q) ? cnt_q + 1'b1 : '0;
      if (cnt_d == CW'(COUNT)) begin
        out_d = ~out_q;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  assign dout = out_q;
endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low matrix, debounces keys and submit, drives key strobes
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int SCAN_DIV = 12500,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  input  logic       submit_btn,
  output logic [3:0] col_n,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] opt,
  output logic       optPressed,
  output logic       submit
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  logic [3:0] r1_q, r2_q, cand_q, cand_d, num_q, num_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0] col_q, col_d;
  logic [15:0] keys_q, keys_d, keys_now;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0] opt_q, opt_d;
  logic num_pressed_q, num_pressed_d, opt_pressed_q, opt_pressed_d;
  logic term, tick, hit, same;
  state_t state_q, state_d;
  scan_t scan;
  always_comb begin
    term = slot_q == SW'(SCAN_DIV - 1);
    tick = term && col_q == 2'd3;
    slot_d = term ? '0 : slot_q + 1'b1;
    col_d = term ? col_q + 2'd1 : col_q;
    keys_now = keys_q;
    for (int r = 0; r < 4; r++) keys_now[{2'(r), col_q}] = ~r2_q[r];
    keys_d = term ? keys_now : keys_q;
    scan = classify(keys_now);
    hit = scan.res == RES_SINGLE;
    same = hit && scan.code == cand_q;
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    num_d = num_q;
    opt_d = opt_q;
    if (tick)
      case (state_q)
        IDLE:
          if (hit) begin
            cand_d = scan.code;
            cnt_d = DW'(1);
            state_d = CONFIRM;
          end
        CONFIRM:
          if (same) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DW'(DEBOUNCE_SCANS)) begin
              state_d = HELD;
              cnt_d = '0;
              num_d = (cand_q <= KEY_DIGIT_MAX) ? cand_q : num_q;
              opt_d = (cand_q <= KEY_DIGIT_MAX) ? opt_q : 3'(cand_q - KEY_OPT_BASE);
            end
          end else if (hit) begin
            cand_d = scan.code;
            cnt_d = DW'(1);
          end else state_d = IDLE;
        HELD:
          if (same) cnt_d = '0;
          else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DW'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              cnt_d = '0;
            end
          end
        default: state_d = IDLE;
      endcase
    num_pressed_d = state_d == HELD && cand_d <= KEY_DIGIT_MAX;
    opt_pressed_d = state_d == HELD && cand_d > KEY_DIGIT_MAX;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r1_q <= '0;
      r2_q <= '1;
      slot_q <= '0;
      col_q <= '0;
      keys_q <= '0;
      state_q <= IDLE;
      cand_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
      opt_q <= '0;
      num_pressed_q <= 1'b0;
      opt_pressed_q <= 1'b0;
    end else begin
      r1_q <= row_n;
      r2_q <= r1_q;
      slot_q <= slot_d;
      col_q <= col_d;
      keys_q <= keys_d;
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      opt_q <= opt_d;
      num_pressed_q <= num_pressed_d;
      opt_pressed_q <= opt_pressed_d;
    end
  key_debounce #(.COUNT(DEBOUNCE_SCANS)) u_submit (
    .clk (clk),
    .rst (reset),
    .en  (tick),
    .din (submit_btn),
    .dout(submit)
  );
  assign col_n = ~(4'b0001 << col_q);
  assign num = num_q;
  assign opt = opt_q;
  assign numPressed = num_pressed_q;
  assign optPressed = opt_pressed_q;
endmodule
